// File: rtl/tl_a_fragment_sequencer.sv
// rtl/tl_a_fragment_sequencer.sv - splits multi-beat TL-A Gets into single-beat Gets for a narrow manager
module tl_a_fragment_sequencer #(
  parameter int MAX_LG_SIZE = 3,
  parameter int ADDR_W      = 33,
  parameter int SOURCE_W    = 6,
  parameter int MASK_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [2:0]          io_in_bits_opcode,
  input  logic [2:0]          io_in_bits_param,
  input  logic [2:0]          io_in_bits_size,
  input  logic [SOURCE_W-1:0] io_in_bits_source,
  input  logic [ADDR_W-1:0]   io_in_bits_address,
  input  logic [MASK_W-1:0]   io_in_bits_mask,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [2:0]          io_out_bits_opcode,
  output logic [2:0]          io_out_bits_param,
  output logic [2:0]          io_out_bits_size,
  output logic [SOURCE_W-1:0] io_out_bits_source,
  output logic [ADDR_W-1:0]   io_out_bits_address,
  output logic [MASK_W-1:0]   io_out_bits_mask,
  output logic [4:0]          io_out_frag,
  output logic                io_out_last,
  output logic                io_busy,
  output logic                io_error
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [2:0] MAX_SZ = 3'(MAX_LG_SIZE);
  localparam logic [2:0] OP_GET = 3'd4;

  state_t              state;
  logic [3:0]          idx;
  logic [2:0]          base_opcode;
  logic [2:0]          base_param;
  logic [2:0]          base_size;
  logic [SOURCE_W-1:0] base_source;
  logic [ADDR_W-1:0]   base_address;

  logic                in_split;
  logic                in_fire;
  logic                out_fire;
  logic [4:0]          in_n_m1;
  logic [4:0]          base_n_m1;
  logic [ADDR_W-1:0]   burst_address;

  assign in_split  = (io_in_bits_opcode == OP_GET) && (io_in_bits_size > MAX_SZ);
  // Only meaningful for split requests; the subtraction underflows otherwise.
  assign in_n_m1   = (5'd1 << (io_in_bits_size - MAX_SZ)) - 5'd1;
  assign base_n_m1 = (5'd1 << (base_size - MAX_SZ)) - 5'd1;
  assign burst_address = base_address + (ADDR_W'(idx) << MAX_LG_SIZE);

  assign in_fire  = io_in_valid && io_in_ready;
  assign out_fire = io_out_valid && io_out_ready;

  always_comb begin
    io_in_ready         = 1'b0;
    io_out_valid        = 1'b0;
    io_out_bits_opcode  = io_in_bits_opcode;
    io_out_bits_param   = io_in_bits_param;
    io_out_bits_size    = io_in_bits_size;
    io_out_bits_source  = io_in_bits_source;
    io_out_bits_address = io_in_bits_address;
    io_out_bits_mask    = io_in_bits_mask;
    io_out_frag         = 5'd0;
    if (state == IDLE) begin
      io_in_ready  = reset && io_out_ready;
      io_out_valid = reset && io_in_valid;
      if (in_split) begin
        io_out_bits_size = MAX_SZ;
        io_out_bits_mask = '1;
        io_out_frag      = in_n_m1;
      end
    end else begin
      io_out_valid        = reset;
      io_out_bits_opcode  = base_opcode;
      io_out_bits_param   = base_param;
      io_out_bits_size    = MAX_SZ;
      io_out_bits_source  = base_source;
      io_out_bits_address = burst_address;
      io_out_bits_mask    = '1;
      io_out_frag         = base_n_m1 - {1'b0, idx};
    end
  end

  assign io_out_last = (io_out_frag == 5'd0);
  assign io_busy     = reset && (state == BURST);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 4'd0;
      io_error <= 1'b0;
    end else begin
      io_error <= in_fire && (io_in_bits_opcode != OP_GET) && (io_in_bits_size > MAX_SZ);
      case (state)
        IDLE: begin
          if (in_fire && in_split) begin
            state <= BURST;
            idx   <= 4'd1;
          end
        end
        BURST: begin
          if (out_fire) begin
            if ({1'b0, idx} == base_n_m1) begin
              state <= IDLE;
              idx   <= 4'd0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request copy is only consumed in BURST, so it needs no reset.
  always_ff @(posedge clock) begin
    if (state == IDLE && in_fire && in_split) begin
      base_opcode  <= io_in_bits_opcode;
      base_param   <= io_in_bits_param;
      base_size    <= io_in_bits_size;
      base_source  <= io_in_bits_source;
      base_address <= io_in_bits_address;
    end
  end

endmodule

// File: tb/tb_tl_a_fragment_sequencer.sv
// tb/tb_tl_a_fragment_sequencer.sv - bench for tl_a_fragment_sequencer: vector table, directed sequences, random vs queue model
module tb_tl_a_fragment_sequencer;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  sz;
    logic [5:0]  src;
    logic [32:0] addr;
    logic [7:0]  mask;
  } req_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  sz;
    logic [5:0]  src;
    logic [32:0] addr;
    logic [7:0]  mask;
    logic [4:0]  frag;
  } frag_t;

  typedef struct {
    logic        iv;
    req_t        r;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [2:0]  esz;
    logic [7:0]  emask;
    logic [32:0] eaddr;
    logic [4:0]  efrag;
    logic        elast;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid;
  logic        io_in_ready;
  logic [2:0]  io_in_bits_opcode;
  logic [2:0]  io_in_bits_param;
  logic [2:0]  io_in_bits_size;
  logic [5:0]  io_in_bits_source;
  logic [32:0] io_in_bits_address;
  logic [7:0]  io_in_bits_mask;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [2:0]  io_out_bits_opcode;
  logic [2:0]  io_out_bits_param;
  logic [2:0]  io_out_bits_size;
  logic [5:0]  io_out_bits_source;
  logic [32:0] io_out_bits_address;
  logic [7:0]  io_out_bits_mask;
  logic [4:0]  io_out_frag;
  logic        io_out_last;
  logic        io_busy;
  logic        io_error;

  tl_a_fragment_sequencer dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_bits_opcode(io_in_bits_opcode), .io_in_bits_param(io_in_bits_param),
    .io_in_bits_size(io_in_bits_size), .io_in_bits_source(io_in_bits_source),
    .io_in_bits_address(io_in_bits_address), .io_in_bits_mask(io_in_bits_mask),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_bits_opcode(io_out_bits_opcode), .io_out_bits_param(io_out_bits_param),
    .io_out_bits_size(io_out_bits_size), .io_out_bits_source(io_out_bits_source),
    .io_out_bits_address(io_out_bits_address), .io_out_bits_mask(io_out_bits_mask),
    .io_out_frag(io_out_frag), .io_out_last(io_out_last),
    .io_busy(io_busy), .io_error(io_error)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  frag_t       pend[$];
  logic [32:0] fired[$];
  logic        exp_err = 1'b0;

  logic        s_valid, s_ready, s_busy, s_err, s_last;
  logic [2:0]  s_size;
  logic [7:0]  s_mask;
  logic [32:0] s_addr;
  logic [4:0]  s_frag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [2:0] sz,
                              input logic [32:0] addr, input logic [7:0] mask);
    req_t r;
    r.op = op; r.param = 3'd1; r.sz = sz; r.src = 6'h15; r.addr = addr; r.mask = mask;
    return r;
  endfunction

  function automatic logic is_split(input req_t r);
    return (r.op == 3'd4) && (r.sz > 3'd3);
  endfunction

  function automatic int nfrags(input req_t r);
    return is_split(r) ? (1 << (int'(r.sz) - 3)) : 1;
  endfunction

  // Fragment i of request r: a split Get becomes N 8-byte Gets walking upward.
  function automatic frag_t frag_of(input req_t r, input int i);
    frag_t f;
    f.op = r.op; f.param = r.param; f.src = r.src;
    if (is_split(r)) begin
      f.sz   = 3'd3;
      f.mask = 8'hFF;
      f.addr = r.addr + 33'(i * 8);
      f.frag = 5'(nfrags(r) - 1 - i);
    end else begin
      f.sz = r.sz; f.mask = r.mask; f.addr = r.addr; f.frag = 5'd0;
    end
    return f;
  endfunction

  task automatic step(input logic iv, input req_t r, input logic ordy, input logic rst);
    logic  ev, er, eb, fire, next_err;
    frag_t ef;
    reset = rst; io_in_valid = iv; io_out_ready = ordy;
    io_in_bits_opcode = r.op; io_in_bits_param = r.param; io_in_bits_size = r.sz;
    io_in_bits_source = r.src; io_in_bits_address = r.addr; io_in_bits_mask = r.mask;
    @(negedge clock);
    s_valid = io_out_valid; s_ready = io_in_ready; s_busy = io_busy; s_err = io_error;
    s_last = io_out_last; s_size = io_out_bits_size; s_mask = io_out_bits_mask;
    s_addr = io_out_bits_address; s_frag = io_out_frag;
    ef = frag_of(r, 0);
    if (!rst) begin
      ev = 1'b0; er = 1'b0; eb = 1'b0;
    end else if (pend.size() > 0) begin
      ev = 1'b1; er = 1'b0; eb = 1'b1; ef = pend[0];
    end else begin
      ev = iv; er = ordy; eb = 1'b0;
    end
    chk("out_valid", 64'(s_valid), 64'(ev));
    chk("in_ready", 64'(s_ready), 64'(er));
    chk("busy", 64'(s_busy), 64'(eb));
    chk("error", 64'(s_err), 64'(exp_err));
    if (ev) begin
      chk("opcode", 64'(io_out_bits_opcode), 64'(ef.op));
      chk("param", 64'(io_out_bits_param), 64'(ef.param));
      chk("source", 64'(io_out_bits_source), 64'(ef.src));
      chk("size", 64'(s_size), 64'(ef.sz));
      chk("mask", 64'(s_mask), 64'(ef.mask));
      chk("address", 64'(s_addr), 64'(ef.addr));
      chk("frag", 64'(s_frag), 64'(ef.frag));
      chk("last", 64'(s_last), 64'(ef.frag == 5'd0));
    end
    fire = ev && ordy;
    next_err = 1'b0;
    if (fire) fired.push_back(s_addr);
    if (!rst) begin
      pend.delete();
    end else if (pend.size() > 0) begin
      if (fire) void'(pend.pop_front());
    end else if (fire) begin
      for (int i = 1; i < nfrags(r); i++) pend.push_back(frag_of(r, i));
      next_err = (r.op != 3'd4) && (r.sz > 3'd3);
    end
    @(posedge clock);
    #1;
    exp_err = next_err;
  endtask

  vec_t vecs[8];

  initial begin
    req_t idle_r, ga, gb;
    logic [6:0] bp;
    logic [32:0] exp_bp[4];

    vecs[0] = '{1'b1, mk(3'd0, 3'd3, 33'h1000, 8'hFF), 1'b1, 1'b1, 1'b1, 3'd3, 8'hFF, 33'h1000, 5'd0, 1'b1};
    vecs[1] = '{1'b1, mk(3'd4, 3'd5, 33'h2000, 8'h0F), 1'b0, 1'b1, 1'b0, 3'd3, 8'hFF, 33'h2000, 5'd3, 1'b0};
    vecs[2] = '{1'b1, mk(3'd4, 3'd7, 33'h8000, 8'h01), 1'b0, 1'b1, 1'b0, 3'd3, 8'hFF, 33'h8000, 5'd15, 1'b0};
    vecs[3] = '{1'b1, mk(3'd4, 3'd3, 33'h0040, 8'hF0), 1'b1, 1'b1, 1'b1, 3'd3, 8'hF0, 33'h0040, 5'd0, 1'b1};
    vecs[4] = '{1'b1, mk(3'd4, 3'd4, 33'h0100, 8'h00), 1'b0, 1'b1, 1'b0, 3'd3, 8'hFF, 33'h0100, 5'd1, 1'b0};
    vecs[5] = '{1'b1, mk(3'd1, 3'd5, 33'h0600, 8'h3C), 1'b0, 1'b1, 1'b0, 3'd5, 8'h3C, 33'h0600, 5'd0, 1'b1};
    vecs[6] = '{1'b0, mk(3'd4, 3'd6, 33'h0900, 8'hFF), 1'b1, 1'b0, 1'b1, 3'd0, 8'h00, 33'h0, 5'd0, 1'b0};
    vecs[7] = '{1'b1, mk(3'd2, 3'd2, 33'h0007, 8'h0F), 1'b1, 1'b1, 1'b1, 3'd2, 8'h0F, 33'h0007, 5'd0, 1'b1};
    idle_r = mk(3'd0, 3'd0, 33'h0, 8'h00);

    reset = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
    io_in_bits_opcode = '0; io_in_bits_param = '0; io_in_bits_size = '0;
    io_in_bits_source = '0; io_in_bits_address = '0; io_in_bits_mask = '0;
    @(posedge clock);
    #1;

    // Reset with a live request offered: nothing may move.
    step(1'b1, mk(3'd0, 3'd3, 33'h10, 8'hFF), 1'b1, 1'b0);
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_error", 64'(s_err), 64'd0);

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].iv, vecs[i].r, vecs[i].ordy, 1'b1);
      chk($sformatf("vec%0d_valid", i), 64'(s_valid), 64'(vecs[i].ev));
      chk($sformatf("vec%0d_ready", i), 64'(s_ready), 64'(vecs[i].er));
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_size", i), 64'(s_size), 64'(vecs[i].esz));
        chk($sformatf("vec%0d_mask", i), 64'(s_mask), 64'(vecs[i].emask));
        chk($sformatf("vec%0d_addr", i), 64'(s_addr), 64'(vecs[i].eaddr));
        chk($sformatf("vec%0d_frag", i), 64'(s_frag), 64'(vecs[i].efrag));
        chk($sformatf("vec%0d_last", i), 64'(s_last), 64'(vecs[i].elast));
      end
    end

    // Split Get at full rate.
    fired.delete();
    step(1'b1, mk(3'd4, 3'd5, 33'h2000, 8'h0F), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, idle_r, 1'b1, 1'b1);
      chk("split_in_ready_low", 64'(s_ready), 64'd0);
    end
    step(1'b0, idle_r, 1'b1, 1'b1);
    chk("split_idle_after", 64'(s_busy), 64'd0);
    chk("split_count", 64'(fired.size()), 64'd4);
    if (fired.size() == 4) begin
      chk("split_a0", 64'(fired[0]), 64'h2000);
      chk("split_a1", 64'(fired[1]), 64'h2008);
      chk("split_a2", 64'(fired[2]), 64'h2010);
      chk("split_a3", 64'(fired[3]), 64'h2018);
    end

    // Backpressure pattern 1,0,0,1,1,0,1; the request stays offered throughout.
    fired.delete();
    bp = 7'b1011001;
    exp_bp[0] = 33'h2000; exp_bp[1] = 33'h2008; exp_bp[2] = 33'h2010; exp_bp[3] = 33'h2018;
    for (int i = 0; i < 7; i++) step(1'b1, mk(3'd4, 3'd5, 33'h2000, 8'h0F), bp[i], 1'b1);
    chk("bp_count", 64'(fired.size()), 64'd4);
    for (int i = 0; i < 4 && i < fired.size(); i++)
      chk($sformatf("bp_addr%0d", i), 64'(fired[i]), 64'(exp_bp[i]));

    // Address wrap at 2^33.
    fired.delete();
    step(1'b1, mk(3'd4, 3'd4, 33'h1_FFFF_FFF8, 8'hFF), 1'b1, 1'b1);
    step(1'b0, idle_r, 1'b1, 1'b1);
    chk("wrap_count", 64'(fired.size()), 64'd2);
    if (fired.size() == 2) begin
      chk("wrap_a0", 64'(fired[0]), 64'h1_FFFF_FFF8);
      chk("wrap_a1", 64'(fired[1]), 64'h0);
    end

    // Oversized Put passes through and flags an error for exactly one cycle.
    step(1'b1, mk(3'd0, 3'd5, 33'h3000, 8'hAA), 1'b1, 1'b1);
    chk("err_pass_size", 64'(s_size), 64'd5);
    step(1'b0, idle_r, 1'b1, 1'b1);
    chk("err_pulse", 64'(s_err), 64'd1);
    step(1'b0, idle_r, 1'b1, 1'b1);
    chk("err_clear", 64'(s_err), 64'd0);

    // Back-to-back: second Get waits out the one-cycle bubble.
    ga = mk(3'd4, 3'd4, 33'h0A00, 8'hFF);
    gb = mk(3'd4, 3'd4, 33'h0B00, 8'hFF);
    step(1'b1, ga, 1'b1, 1'b1);
    step(1'b1, gb, 1'b1, 1'b1);
    chk("b2b_last_ready", 64'(s_ready), 64'd0);
    chk("b2b_last_addr", 64'(s_addr), 64'h0A08);
    step(1'b1, gb, 1'b1, 1'b1);
    chk("b2b_accept_ready", 64'(s_ready), 64'd1);
    chk("b2b_accept_addr", 64'(s_addr), 64'h0B00);
    step(1'b0, idle_r, 1'b1, 1'b1);

    // Reset mid-burst abandons the rest of the Get.
    step(1'b1, mk(3'd4, 3'd6, 33'h4000, 8'hFF), 1'b1, 1'b1);
    step(1'b0, idle_r, 1'b1, 1'b1);
    step(1'b0, idle_r, 1'b1, 1'b1);
    step(1'b1, mk(3'd0, 3'd2, 33'h5000, 8'h0F), 1'b1, 1'b0);
    chk("midrst_valid", 64'(s_valid), 64'd0);
    chk("midrst_ready", 64'(s_ready), 64'd0);
    step(1'b0, idle_r, 1'b1, 1'b1);
    chk("midrst_busy", 64'(s_busy), 64'd0);
    step(1'b1, mk(3'd0, 3'd2, 33'h5000, 8'h0F), 1'b1, 1'b1);
    chk("midrst_put_valid", 64'(s_valid), 64'd1);
    chk("midrst_put_addr", 64'(s_addr), 64'h5000);
    chk("midrst_put_frag", 64'(s_frag), 64'd0);

    // Random traffic against the fragment-queue model.
    for (int i = 0; i < 3000; i++) begin
      req_t rr;
      logic [31:0] lo;
      lo = $urandom;
      rr.op    = ($urandom_range(0, 1) == 1) ? 3'd4 : 3'($urandom_range(0, 7));
      rr.param = 3'($urandom_range(0, 7));
      rr.sz    = 3'($urandom_range(0, 7));
      rr.src   = 6'($urandom_range(0, 63));
      rr.mask  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) rr.addr = {1'b1, 24'hFFFFFF, lo[7:0]};
      else rr.addr = {lo[0], lo};
      step($urandom_range(0, 2) != 0, rr, $urandom_range(0, 3) != 0,
           $urandom_range(0, 99) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_a_fragment_sequencer.md
Name: tl_a_fragment_sequencer

Overview:
- Sequences a TileLink A-channel request stream between a client port and a narrower manager port.
- Get requests larger than one beat are split into a series of single-beat Gets with incrementing addresses. The block holds the original request and replays it until the burst is exhausted.
- All other requests pass straight through with zero latency.
- Sits in the fragmenter path in front of narrow slave ports (boot ROM, control registers).

Parameters:
- MAX_LG_SIZE, 3, log2 bytes of the largest fragment the manager accepts (8 B).
- ADDR_W, 33, address width.
- SOURCE_W, 6, source ID width.
- MASK_W, 8, byte mask width; equals 2^MAX_LG_SIZE.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the rising edge of clock)
- io_in_valid  in  1  client request valid
- io_in_ready  out  1  client request accepted
- io_in_bits_opcode  in  3  TL A opcode
- io_in_bits_param  in  3  TL A param
- io_in_bits_size  in  3  log2 request bytes
- io_in_bits_source  in  SOURCE_W  source ID
- io_in_bits_address  in  ADDR_W  byte address
- io_in_bits_mask  in  MASK_W  byte mask
- io_out_valid  out  1  fragment valid
- io_out_ready  in  1  manager accepts fragment
- io_out_bits_opcode/param/size/source/address/mask  out  3/3/3/SOURCE_W/ADDR_W/MASK_W  fragment fields
- io_out_frag  out  5  fragments remaining after this one
- io_out_last  out  1  io_out_frag==0
- io_busy  out  1  burst in progress (state BURST)
- io_error  out  1  one-cycle pulse: non-Get with size>MAX_LG_SIZE accepted

Behaviour:
- Classify each request:
  - Split request: opcode==4 (Get) and size>MAX_LG_SIZE.
  - N = 2^(size-MAX_LG_SIZE) fragments; maximum size 7 gives N up to 16 for MAX=3.
  - Every other request is a single fragment.
- State machine has two states, IDLE and BURST. Registers: base copy of all request fields, idx[3:0].
- IDLE:
  - io_out_valid = io_in_valid.
  - io_in_ready = io_out_ready.
  - Outputs are driven combinationally from io_in (zero latency).
  - For a split request in IDLE: size=MAX_LG_SIZE, mask=all ones, address=in address, frag=N-1.
  - Pass-through request: all fields unmodified, frag=0, last=1.
- IDLE -> BURST: io_in fire with a split request. Capture fields, set idx<=1.
- BURST:
  - io_in_ready=0; io_out_valid=1.
  - Outputs come from saved fields: opcode, param and source saved; size=MAX_LG_SIZE; mask=all ones.
  - address = (base + idx<<MAX_LG_SIZE) mod 2^ADDR_W; wraps at 2^ADDR_W with no carry-out.
  - frag = N-1-idx.
- BURST transitions:
  - Out fire with idx<N-1: idx<=idx+1.
  - Out fire with idx==N-1: go to IDLE, idx<=0.
- No fire: all state holds. Fields stay stable under backpressure, per TL rules.
- Last fragment: no new request is accepted in the same cycle. io_in_ready rises the next cycle (one-cycle bubble).
- io_error: asserted the cycle after accepting opcode!=4 with size>MAX_LG_SIZE. That request still passes through unmodified.
- Reset (reset==0):
  - state<=IDLE, idx<=0, io_error<=0.
  - While reset is low: io_in_ready=0, io_out_valid=0, io_busy=0.
  - Saved field registers are not reset.
  - Reset mid-burst abandons the remaining fragments.
- io_busy = (state==BURST).

Test Plan:
- Pass-through: Put opcode 0, size 3, addr 0x1000, mask 0xFF, out_ready=1 -> same cycle out fires unchanged, frag=0, last=1, busy stays 0.
- Split Get: opcode 4, size 5, addr 0x2000, out_ready=1 -> 4 fragments at 0x2000/0x2008/0x2010/0x2018, size 3, mask 0xFF, frag 3,2,1,0; in_ready low for cycles 2-4; IDLE after cycle 4.
- Backpressure: same Get with out_ready toggled 1,0,0,1,1,0,1 -> fragment fields held during stalls; exactly 4 fires in order; no duplicate or skipped address.
- Address wrap: Get size 4, addr 0x1_FFFF_FFF8 -> fragments 0x1_FFFF_FFF8 then 0x0_0000_0000.
- Error and back-to-back: Put size 5 accepted -> passes through, io_error pulses once next cycle. Then a Get size 4 offered while the prior burst finishes -> accepted only the cycle after the previous last fragment.
- Reset mid-burst: Get size 6, reset=0 after 3 fragments for 1 cycle -> out_valid=0 and in_ready=0 during reset; IDLE, busy=0 afterwards; a new Put size 2 passes through normally.
